// File: rtl/fft_cfg_pkg.sv
// Shared configuration for the FFT wrapper datapath: frame geometry, read-FSM
// and bank-state encodings used by the feeder, the FFT wrapper and the readout stage.
package fft_cfg_pkg;

    localparam int FRAME_LEN = 1024;
    localparam int ADDR_W    = 10;
    localparam int SAMPLE_W  = 16;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_STREAM,
        R_WAIT_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        READING
    } bank_state_t;

endpackage

// File: rtl/fft_feed_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// The two banks are never read and written at the same address, so no bypass.
module fft_feed_dpram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame capture for the FFT: fills one bank while the other is
// streamed to the FFT with zero-latency consume, releasing a bank on i_fft_done.
module fft_frame_feeder
    import fft_cfg_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_fft_mode,
    output logic                o_start,
    input  logic                i_data_en,
    output logic [31:0]         o_data,
    input  logic                i_fft_done,
    output logic                o_overflow,
    output logic                o_busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    bank_state_t          bank_st [2];
    logic                 wr_bank;
    logic                 drop;
    logic [ADDR_W-1:0]    wcnt;

    rd_state_t            state, state_nx;
    logic                 rd_bank;
    logic [ADDR_W-1:0]    rcnt;
    logic [ADDR_W-1:0]    rcnt_inc;
    logic [ADDR_W-1:0]    rd_idx;
    logic [SAMPLE_W-1:0]  rd_q;

    logic issue, consume, free, we, wr_last, other_free, full_avail, sel;

    assign we         = i_sample_valid && !drop;
    assign wr_last    = we && (wcnt == LAST);
    assign free       = (state == R_WAIT_DONE) && i_fft_done;
    // A bank being released this very cycle counts as empty for the switch.
    assign other_free = (bank_st[~wr_bank] == EMPTY) || (free && (rd_bank == ~wr_bank));
    assign full_avail = (bank_st[0] == FULL) || (bank_st[1] == FULL);
    // The bank not being written is always the older one when both are full.
    assign sel        = (bank_st[~wr_bank] == FULL) ? ~wr_bank : wr_bank;

    always_comb begin
        state_nx = state;
        o_start  = 1'b0;
        issue    = 1'b0;
        consume  = 1'b0;
        case (state)
            R_IDLE: begin
                if (full_avail && i_fft_mode) begin
                    issue    = 1'b1;
                    state_nx = R_START;
                end
            end
            R_START: begin
                o_start = 1'b1;
                if (i_data_en) begin
                    consume  = 1'b1;
                    state_nx = R_STREAM;
                end
            end
            R_STREAM: begin
                if (i_data_en) begin
                    consume = 1'b1;
                    if (rcnt == LAST) state_nx = R_WAIT_DONE;
                end
            end
            R_WAIT_DONE: begin
                if (i_fft_done) state_nx = R_IDLE;
            end
            default: state_nx = R_IDLE;
        endcase
    end

    // Look one ahead on consume so o_data is already the next sample.
    assign rcnt_inc = rcnt + 1'b1;
    assign rd_idx   = consume ? rcnt_inc : rcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= R_IDLE;
            rd_bank <= 1'b0;
            rcnt    <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                rd_bank <= sel;
                rcnt    <= '0;
            end else if (consume) begin
                rcnt <= rcnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            wcnt       <= '0;
            drop       <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (issue) bank_st[sel] <= READING;
            if (free)  bank_st[rd_bank] <= EMPTY;
            if (i_sample_valid && drop) o_overflow <= 1'b1;
            if (drop && free) begin
                drop    <= 1'b0;
                wr_bank <= rd_bank;
            end
            if (we) begin
                wcnt <= wcnt + 1'b1;
                if (wr_last) begin
                    bank_st[wr_bank] <= FULL;
                    if (other_free) wr_bank <= ~wr_bank;
                    else            drop    <= 1'b1;
                end
            end
        end
    end

    fft_feed_dpram #(
        .AW (ADDR_W + 1),
        .DW (SAMPLE_W)
    ) u_ram (
        .clk     (i_clk),
        .we      (we),
        .wr_addr ({wr_bank, wcnt}),
        .wr_data (i_sample),
        .rd_addr ({rd_bank, rd_idx}),
        .rd_data (rd_q)
    );

    assign o_busy = (state != R_IDLE);
    assign o_data = (state == R_START || state == R_STREAM)
                  ? {{(32-SAMPLE_W){rd_q[SAMPLE_W-1]}}, rd_q} : 32'd0;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: streaming, sign extension, ping-pong,
// overflow/drop recovery, gapped consume and mid-stream reset.
module tb_fft_frame_feeder;
    import fft_cfg_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_sample_valid = 1'b0;
    logic [15:0] i_sample = '0;
    logic        i_fft_mode = 1'b1;
    logic        i_data_en = 1'b0;
    logic        i_fft_done = 1'b0;
    logic        o_start, o_overflow, o_busy;
    logic [31:0] o_data;

    int total = 0;
    int bad   = 0;

    fft_frame_feeder dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_fft_mode     (i_fft_mode),
        .o_start        (o_start),
        .i_data_en      (i_data_en),
        .o_data         (o_data),
        .i_fft_done     (i_fft_done),
        .o_overflow     (o_overflow),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame 11000 carries the sign-extension corner values in its first two slots.
    function automatic logic [15:0] frame_val(input int base, input int k);
        if (base == 11000 && k == 0) return 16'h8000;
        if (base == 11000 && k == 1) return 16'h7FFF;
        return 16'(base + k);
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic feed_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            i_sample_valid = 1'b1;
            i_sample       = frame_val(base, i);
            @(negedge i_clk);
        end
        i_sample_valid = 1'b0;
    endtask

    // Consume samples k0..k1-1; i_data_en is high one cycle in every gap+1.
    task automatic stream_frame(input string tag, input int base, input int k0,
                                input int k1, input int gap);
        int k = k0;
        int j = 0;
        while (k < k1) begin
            chk(tag, o_data, sext(frame_val(base, k)));
            i_data_en = ((j % (gap + 1)) == 0);
            @(negedge i_clk);
            if (i_data_en) k++;
            j++;
        end
        i_data_en = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (o_start !== 1'b1 && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, o_start, 1'b1);
    endtask

    task automatic done_pulse(input string tag);
        chk({tag, "_wait_busy"}, o_busy, 1'b1);
        chk({tag, "_wait_start"}, o_start, 1'b0);
        chk({tag, "_wait_data"}, o_data, 32'd0);
        i_fft_done = 1'b1;
        @(negedge i_clk);
        i_fft_done = 1'b0;
        chk({tag, "_idle_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        // reset
        repeat (2) @(negedge i_clk);
        chk("rst_start", o_start, 1'b0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_busy", o_busy, 1'b0);

        // frame A: values 0..1023, o_start one cycle after the last write
        feed_frame(0, 1024);
        chk("A_start_not_yet", o_start, 1'b0);
        @(negedge i_clk);
        chk("A_start_rise", o_start, 1'b1);
        chk("A_busy", o_busy, 1'b1);
        @(negedge i_clk);
        chk("A_prefetch", o_data, 32'd0);
        chk("A_start_held", o_start, 1'b1);

        // frame B captured while A streams
        fork
            stream_frame("A_stream", 0, 0, 1024, 0);
            feed_frame(2000, 1024);
        join
        repeat (3) @(negedge i_clk);
        chk("B_blocked_outstanding", o_start, 1'b0);
        done_pulse("A");
        chk("B_no_start_in_idle", o_start, 1'b0);
        @(negedge i_clk);
        chk("B_start_rise", o_start, 1'b1);
        chk("B_no_ovf", o_overflow, 1'b0);
        @(negedge i_clk);
        stream_frame("B_stream", 2000, 0, 1024, 0);
        done_pulse("B");
        chk("B_ovf_still_0", o_overflow, 1'b0);

        // overflow: two frames held back plus five dropped samples
        i_fft_mode = 1'b0;
        feed_frame(5000, 1024);
        feed_frame(7000, 1024);
        feed_frame(9000, 5);
        chk("ovf_set", o_overflow, 1'b1);
        chk("ovf_mode0_no_start", o_start, 1'b0);
        chk("ovf_mode0_idle", o_busy, 1'b0);
        i_fft_mode = 1'b1;
        wait_start("C1_start");
        @(negedge i_clk);
        stream_frame("C1_stream", 5000, 0, 1024, 0);
        done_pulse("C1");
        wait_start("C2_start");
        @(negedge i_clk);
        fork
            stream_frame("C2_stream", 7000, 0, 1024, 0);
            feed_frame(11000, 1024);
        join
        done_pulse("C2");

        // third frame: starts with the first post-drop sample, gapped consume
        wait_start("D_start");
        @(negedge i_clk);
        chk("D_sext_neg", o_data, 32'hFFFF8000);
        chk("D_start_held", o_start, 1'b1);
        i_data_en = 1'b1;
        @(negedge i_clk);
        chk("D_start_drop", o_start, 1'b0);
        chk("D_sext_pos", o_data, 32'h00007FFF);
        i_data_en = 1'b0;
        stream_frame("D_gapped", 11000, 1, 1024, 2);
        done_pulse("D");
        chk("ovf_sticky", o_overflow, 1'b1);

        // reset in the middle of a stream at rcnt=500
        feed_frame(100, 1024);
        wait_start("E_start");
        @(negedge i_clk);
        stream_frame("E_stream", 100, 0, 500, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_start", o_start, 1'b0);
        chk("mid_rst_data", o_data, 32'd0);
        chk("mid_rst_ovf", o_overflow, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("post_rst_no_start", o_start, 1'b0);
        feed_frame(300, 1023);
        repeat (3) @(negedge i_clk);
        chk("partial_no_start", o_start, 1'b0);
        feed_frame(1323, 1);
        wait_start("F_start");
        @(negedge i_clk);
        chk("F_first_sample", o_data, 32'd300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
